// File: rtl/multiword_add_sequencer_if.sv
// Handshake and operand/result bundle for the multi-word add/subtract sequencer.
// The controller drives the master side; the sequencer implements the slave side.
interface multiword_add_sequencer_if #(
    parameter int BIT_NUMBER = 8,
    parameter int WORDS      = 4
);
    localparam int W = WORDS * BIT_NUMBER;

    logic         start;
    logic         sub;
    logic [W-1:0] num_one;
    logic [W-1:0] num_two;
    logic         busy;
    logic         done;
    logic [W:0]   S;

    modport master (
        output start, sub, num_one, num_two,
        input  busy, done, S
    );

    modport slave (
        input  start, sub, num_one, num_two,
        output busy, done, S
    );
endinterface

// File: rtl/multiword_add_sequencer.sv
// Wide add/subtract built from two narrow CLA slices, one BIT_NUMBER chunk per clock,
// least-significant chunk first, with a carry register linking consecutive chunks.
module multiword_add_sequencer #(
    parameter int BIT_NUMBER = 8,
    parameter int WORDS      = 4
) (
    input logic                     clk,
    input logic                     rst,
    multiword_add_sequencer_if.slave bus
);
    localparam int W  = WORDS * BIT_NUMBER;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [IW-1:0]         r_idx;
    logic                  r_carry;
    logic [W-1:0]          r_num_one;
    logic [W-1:0]          r_num_two;
    logic [W:0]            r_s;
    logic                  r_busy;
    logic                  r_done;
    logic [BIT_NUMBER-1:0] w_a;
    logic [BIT_NUMBER-1:0] w_b;
    logic [BIT_NUMBER:0]   w_s1;
    logic [BIT_NUMBER:0]   w_s2;
    logic                  w_carry_next;

    // Carry-lookahead slice: generate/propagate per bit, returns {carry_out, sum}.
    function automatic logic [BIT_NUMBER:0] cla_add(
        input logic [BIT_NUMBER-1:0] a,
        input logic [BIT_NUMBER-1:0] b,
        input logic                  cin
    );
        logic [BIT_NUMBER-1:0] g;
        logic [BIT_NUMBER-1:0] p;
        logic [BIT_NUMBER:0]   c;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < BIT_NUMBER; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        return {c[BIT_NUMBER], p ^ c[BIT_NUMBER-1:0]};
    endfunction

    assign w_a          = r_num_one[int'(r_idx)*BIT_NUMBER +: BIT_NUMBER];
    assign w_b          = r_num_two[int'(r_idx)*BIT_NUMBER +: BIT_NUMBER];
    assign w_s1         = cla_add(w_a, w_b, 1'b0);
    assign w_s2         = cla_add(w_s1[BIT_NUMBER-1:0], {BIT_NUMBER{1'b0}}, r_carry);
    // The two slice carries are mutually exclusive, so OR gives the chunk carry.
    assign w_carry_next = w_s1[BIT_NUMBER] | w_s2[BIT_NUMBER];

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.S    = r_s;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next_state = RUN;
                end else begin
                    w_next_state = IDLE;
                end
            end
            RUN: begin
                if (r_idx == LAST_IDX) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = RUN;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Operand latch, chunk datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx     <= '0;
            r_carry   <= 1'b0;
            r_num_one <= '0;
            r_num_two <= '0;
            r_s       <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_busy <= (w_next_state != IDLE);
            r_done <= (w_next_state == DONE);
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        // Subtraction is a + ~b + 1: invert b once and seed the carry.
                        r_num_one <= bus.num_one;
                        r_num_two <= bus.sub ? ~bus.num_two : bus.num_two;
                        r_carry   <= bus.sub;
                        r_s       <= '0;
                        r_idx     <= '0;
                    end
                end
                RUN: begin
                    r_s[int'(r_idx)*BIT_NUMBER +: BIT_NUMBER] <= w_s2[BIT_NUMBER-1:0];
                    r_carry <= w_carry_next;
                    if (r_idx == LAST_IDX) begin
                        r_s[W] <= w_carry_next;
                        r_idx  <= '0;
                    end else begin
                        r_idx  <= r_idx + IW'(1);
                    end
                end
                DONE: begin
                    r_idx <= '0;
                end
                default: begin
                    r_idx <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Scoreboard bench for multiword_add_sequencer at BIT_NUMBER=8, WORDS=4.
module tb_multiword_add_sequencer;
    localparam int BN    = 8;
    localparam int WORDS = 4;
    localparam int W     = BN * WORDS;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;
    logic [W:0] sb_q[$];

    multiword_add_sequencer_if #(.BIT_NUMBER(BN), .WORDS(WORDS)) bus ();

    multiword_add_sequencer #(.BIT_NUMBER(BN), .WORDS(WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic [W:0] r;
        if (s) r = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
        else   r = {1'b0, a} + {1'b0, b};
        return r;
    endfunction

    // Scoreboard: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            n_done++;
            if (sb_q.size() == 0) check_value("sb_unexpected_done", 64'd1, 64'd0);
            else                  check_value("S", 64'(bus.S), 64'(sb_q.pop_front()));
        end
    end

    // Present operands for one cycle; returns at the negedge just after the accept edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.num_one = a;
        bus.num_two = b;
        bus.sub     = s;
        sb_q.push_back(model(a, b, s));
        @(negedge clk);
        bus.start   = 1'b0;
        bus.num_one = $urandom;
        bus.num_two = $urandom;
        bus.sub     = 1'($urandom_range(1, 0));
    endtask

    task automatic wait_done(input string tag);
        int lat  = -1;
        int bcnt = 0;
        for (int t = 0; t < 20; t++) begin
            if (bus.busy) bcnt++;
            if (bus.done && lat < 0) lat = t;
            if (!bus.busy) break;
            @(negedge clk);
        end
        check_value({tag, "_latency"}, 64'(lat), 64'(WORDS));
        check_value({tag, "_busy_cycles"}, 64'(bcnt), 64'(WORDS + 1));
    endtask

    initial begin
        int d0;
        int cnt;
        int times[3];
        clk         = 1'b0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.sub     = 1'b0;
        bus.num_one = '0;
        bus.num_two = '0;
        repeat (3) @(negedge clk);
        check_value("reset_busy", 64'(bus.busy), 64'd0);
        check_value("reset_done", 64'(bus.done), 64'd0);
        check_value("reset_S", 64'(bus.S), 64'd0);
        rst = 1'b0;

        d0 = n_done;
        issue(32'h0000_00FF, 32'h0000_0001, 1'b0);
        wait_done("t1");
        check_value("t1_done_count", 64'(n_done - d0), 64'd1);

        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        wait_done("t2");
        issue(32'h0000_0005, 32'h0000_0007, 1'b1);
        wait_done("t3a");
        issue(32'h1234_5678, 32'h0000_0078, 1'b1);
        wait_done("t3b");

        // Start pulses during RUN and during DONE must be ignored.
        d0 = n_done;
        issue(32'h1111_1111, 32'h2222_2222, 1'b0);
        @(negedge clk);
        bus.start = 1'b1; bus.num_one = 32'hDEAD_BEEF; bus.num_two = 32'h0BAD_F00D;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check_value("t4_done_in_done_state", 64'(bus.done), 64'd1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        check_value("t4_done_count", 64'(n_done - d0), 64'd1);
        check_value("t4_idle_busy", 64'(bus.busy), 64'd0);

        // Mid-RUN reset discards the operation.
        d0 = n_done;
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        check_value("t5_busy", 64'(bus.busy), 64'd0);
        check_value("t5_done", 64'(bus.done), 64'd0);
        check_value("t5_S", 64'(bus.S), 64'd0);
        repeat (8) @(negedge clk);
        check_value("t5_no_done", 64'(n_done - d0), 64'd0);
        bus.start = 1'b1;
        rst       = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        rst       = 1'b0;
        check_value("t5_rst_wins_busy", 64'(bus.busy), 64'd0);
        issue(32'h0000_0001, 32'h0000_0002, 1'b0);
        wait_done("t5_fresh");

        // Start held high: back-to-back accepts.
        repeat (3) sb_q.push_back(model(32'h8000_0000, 32'h8000_0000, 1'b0));
        cnt = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.num_one = 32'h8000_0000; bus.num_two = 32'h8000_0000; bus.sub = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (bus.done) begin
                times[cnt] = t;
                cnt++;
                if (cnt == 3) begin
                    bus.start = 1'b0;
                    break;
                end
            end
        end
        bus.start = 1'b0;
        check_value("t6_done_count", 64'(cnt), 64'd3);
        if (cnt == 3) begin
            check_value("t6_spacing_1", 64'(times[1] - times[0]), 64'(WORDS + 2));
            check_value("t6_spacing_2", 64'(times[2] - times[1]), 64'(WORDS + 2));
        end
        repeat (10) @(negedge clk);
        check_value("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/multiword_add_sequencer.md
# multiword_add_sequencer

Sequences a wide addition or subtraction of WORDS×BIT_NUMBER-bit operands through narrow BIT_NUMBER-bit carry-lookahead adder slices, one chunk per clock, least-significant chunk first. An inter-chunk carry register links the chunks. It trades latency for area when 64-bit and wider sums are needed without a full-width CLA. A start/busy/done handshake connects it to the surrounding control logic.

## Interface
Parameters:
- BIT_NUMBER, 8, chunk width handled per cycle (width of each internal nbit_CLA_full_adder instance)
- WORDS, 4, number of chunks; operand width W = WORDS×BIT_NUMBER; WORDS ≥ 2

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a new operation; sampled only in IDLE
- sub  input  1  0: num_one + num_two; 1: num_one − num_two; latched with start
- num_one  input  W  first operand; latched on accept
- num_two  input  W  second operand; latched on accept
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse; S valid
- S  output  W+1  result: {carry_out, sum[W-1:0]}; held until the next accept

## Operation
- States: IDLE, RUN, DONE.
  - IDLE: on start=1, latch num_one, num_two and sub, clear S, set idx=0, go to RUN.
  - RUN: process chunk idx; idx increments by 1 each cycle; after idx=WORDS−1, go to DONE.
  - DONE: done=1, then unconditionally return to IDLE.
- Accept condition: start=1 while state=IDLE. Start in RUN or DONE is ignored, not queued.
- Subtraction:
  - On accept with sub=1, the latched num_two is replaced by ~num_two and the carry register initialises to 1.
  - With sub=0, the carry register initialises to 0.
- Per RUN cycle, with a = chunk idx of latched num_one and b = chunk idx of latched (possibly inverted) num_two:
  - Adder 1: s1 = a + b, giving BIT_NUMBER+1 bits.
  - Adder 2: s2 = s1[BIT_NUMBER-1:0] + {0…0, carry}, giving BIT_NUMBER+1 bits.
  - S chunk idx ← s2[BIT_NUMBER-1:0].
  - carry ← s1[BIT_NUMBER] | s2[BIT_NUMBER]. At most one of the two can be 1.
- The move to DONE writes S[W] ← final carry.
- Subtraction result interpretation:
  - S[W-1:0] is the two's-complement difference.
  - S[W] = 1 means no borrow (num_one ≥ num_two unsigned); S[W] = 0 means a borrow occurred.
- Operand inputs are don't-care outside the accept cycle; only the latched copies are used.
- Reset (in any state, including mid-RUN):
  - state ← IDLE, idx ← 0, carry ← 0, S ← 0, busy ← 0, done ← 0.
  - The in-flight operation is discarded and no done is issued for it.

## Timing
- Reset values: busy=0, done=0, S=0, internal state IDLE.
- Let accept occur at rising edge k.
  - busy=1 from after edge k through after edge k+WORDS.
  - Chunk i is written at edge k+1+i.
  - done=1 and S fully valid from after edge k+WORDS until edge k+WORDS+1, i.e. for exactly one cycle.
  - busy=0 again after edge k+WORDS+1.
- Latency from accept to done: WORDS cycles.
- Throughput with start held high: one accept every WORDS+2 cycles. Accept happens at the first IDLE cycle after DONE; there is no DONE→RUN shortcut.
- S is intermediate and not meaningful while busy=1 and done=0. After done, S stays stable until the next accept, which clears it.
- Start and rst asserted together: rst wins; no accept occurs.

## Test plan
Parameters: BIT_NUMBER=8, WORDS=4.
1. num_one=0x000000FF, num_two=0x00000001, sub=0, start one cycle → exactly one done pulse 4 cycles after the accept edge, S=0x0_00000100, busy high for 5 cycles.
2. num_one=0xFFFFFFFF, num_two=0x00000001, sub=0 → full ripple through all chunks, S=0x1_00000000.
3. num_one=0x00000005, num_two=0x00000007, sub=1 → S=0x0_FFFFFFFE (borrow). Then num_one=0x12345678, num_two=0x00000078, sub=1 → S=0x1_12345600.
4. Accept 0x11111111+0x22222222, then pulse start with different operands during RUN and during DONE → both ignored, single done pulse, S=0x0_33333333.
5. Accept 0xFFFFFFFF+0xFFFFFFFF, assert rst for one cycle two cycles after accept → busy=0, done=0, S=0 the cycle after reset, no done pulse. A fresh 0x1+0x2 then completes with S=0x0_00000003.
6. start held high continuously with fixed operands 0x80000000+0x80000000 → done pulses exactly 6 cycles apart, each with S=0x1_00000000.
